uart_echo_responder: RTL and testbench

Far-end responder for the UART link. It consumes bytes from a UART receiver (rx_data, rx_ready, rx_error), buffers them in a small FIFO, and retransmits each one through a UART transmitter using a tx_start/tx_busy handshake. This closes the loop for link bring-up and for board-level echo tests. It also keeps saturating counts of framing errors and overflow drops.

---
 rtl/uart_defs.sv | 6 +
 rtl/uart_sync_fifo.sv | 39 +++
 rtl/uart_echo_responder.sv | 75 +++++++
 tb/tb_uart_echo_responder.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_defs.sv
// uart_defs: shared byte width, default substitute byte and echo TX FSM states.
package uart_defs;
  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] DEF_ERR_BYTE = 8'h3F;
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} tx_state_t;
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: circular-buffer FIFO with first-word-fall-through head.
module uart_sync_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic do_push, do_pop;
  assign empty = level == '0;
  assign full = level == LW'(DEPTH);
  assign do_pop = pop & ~empty;
  // a pop in the same cycle frees the slot the push lands in
  assign do_push = push & (~full | do_pop);
  assign dout = mem[rptr];
  always_ff @(posedge clk)
    if (do_push) mem[wptr] <= din;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop) rptr <= rptr + AW'(1);
      level <= level + LW'(do_push) - LW'(do_pop);
    end
endmodule

// File: rtl/uart_echo_responder.sv
// uart_echo_responder: buffers received bytes and re-sends each through a
// tx_start/tx_busy transmitter handshake, counting framing errors and drops.
module uart_echo_responder
  import uart_defs::*;
#(
  parameter int DEPTH = 16,
  parameter bit ERR_SUBST = 1'b1,
  parameter logic [7:0] ERR_BYTE = DEF_ERR_BYTE,
  parameter int BUSY_TIMEOUT = 8,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   echo_en,
  input  logic [7:0]             rx_data,
  input  logic                   rx_ready,
  input  logic                   rx_error,
  input  logic                   tx_busy,
  output logic                   tx_start,
  output logic [7:0]             tx_data,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [CNT_W-1:0]       error_cnt,
  output logic [CNT_W-1:0]       overflow_cnt
);
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  tx_state_t state, state_n;
  logic rx_ready_q, take, cand, pop, drop, full, empty;
  logic [BYTE_W-1:0] cand_byte, head;
  logic [TW-1:0] wait_cnt;
  assign take = rx_ready & ~rx_ready_q & echo_en;
  assign cand = take & (~rx_error | ERR_SUBST);
  assign cand_byte = rx_error ? ERR_BYTE : rx_data;
  assign pop = state == LAUNCH;
  assign drop = cand & full & ~pop;
  uart_sync_fifo #(.W(BYTE_W), .DEPTH(DEPTH)) fifo (
    .clk(clk),
    .reset(reset),
    .push(cand),
    .pop(pop),
    .din(cand_byte),
    .dout(head),
    .level(fifo_level),
    .full(full),
    .empty(empty)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = (!empty && !tx_busy) ? LAUNCH : IDLE;
      LAUNCH:    state_n = WAIT_BUSY;
      // a transmitter that never acknowledges must not stall the echo stream
      WAIT_BUSY: state_n = tx_busy ? WAIT_DONE : (wait_cnt == TW'(BUSY_TIMEOUT - 1)) ? IDLE : WAIT_BUSY;
      WAIT_DONE: state_n = tx_busy ? WAIT_DONE : IDLE;
      default:   state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      rx_ready_q <= 1'b1;
      tx_start <= 1'b0;
      tx_data <= '0;
      wait_cnt <= '0;
      error_cnt <= '0;
      overflow_cnt <= '0;
    end else begin
      state <= state_n;
      rx_ready_q <= rx_ready;
      tx_start <= pop;
      if (pop) tx_data <= head;
      wait_cnt <= (state == WAIT_BUSY) ? wait_cnt + TW'(1) : '0;
      if (take && rx_error && !(&error_cnt)) error_cnt <= error_cnt + CNT_W'(1);
      if (drop && !(&overflow_cnt)) overflow_cnt <= overflow_cnt + CNT_W'(1);
    end
endmodule

// File: tb/tb_uart_echo_responder.sv
// tb_uart_echo_responder: random and directed echo traffic against a queue model.
module tb_uart_echo_responder;
  localparam int DEPTH = 16;
  localparam int BT = 8;
  logic clk = 1'b0, reset = 1'b1, echo_en = 1'b1;
  logic rx_ready = 1'b1, rx_error = 1'b0, tx_busy = 1'b0;
  logic rx_ready0 = 1'b0, busy0 = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic tx_start, tx_start0;
  logic [7:0] tx_data, tx_data0, error_cnt, overflow_cnt, error_cnt0, overflow_cnt0;
  logic [4:0] fifo_level, fifo_level0;
  logic [7:0] q[$];
  logic [7:0] last_tx = 8'h00;
  int n_cmp = 0, n_bad = 0, cyc = 0, err_m = 0, ovf_m = 0;
  int starts = 0, starts0 = 0, last_start = 0, prev_start = 0, rise_in = 0, busy_left = 0;
  int s0, c0;
  bit prev_ready = 1'b1, hold_busy = 1'b0, never_busy = 1'b0;

  always #5 clk = ~clk;

  uart_echo_responder dut (
    .clk(clk), .reset(reset), .echo_en(echo_en), .rx_data(rx_data), .rx_ready(rx_ready),
    .rx_error(rx_error), .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
    .fifo_level(fifo_level), .error_cnt(error_cnt), .overflow_cnt(overflow_cnt)
  );

  uart_echo_responder #(.ERR_SUBST(1'b0)) dut0 (
    .clk(clk), .reset(reset), .echo_en(echo_en), .rx_data(rx_data), .rx_ready(rx_ready0),
    .rx_error(rx_error), .tx_busy(busy0), .tx_start(tx_start0), .tx_data(tx_data0),
    .fifo_level(fifo_level0), .error_cnt(error_cnt0), .overflow_cnt(overflow_cnt0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // one clock: apply inputs, advance the echo model, check, then play transmitter
  task automatic step();
    logic r, e, en, b;
    logic [7:0] d, v;
    r = rx_ready; e = rx_error; en = echo_en; b = tx_busy; d = rx_data;
    @(posedge clk);
    #1;
    cyc++;
    if (tx_start0) starts0++;
    if (tx_start) begin
      check("start_while_busy", b, 1'b0);
      check("start_has_byte", q.size() > 0, 1);
      v = 8'h00;
      if (q.size() > 0) v = q.pop_front();
      check("echo_byte", tx_data, v);
      last_tx = v;
      starts++;
      prev_start = last_start;
      last_start = cyc;
      if (!never_busy) rise_in = $urandom_range(1, 3);
    end
    if (r && !prev_ready && en) begin
      if (e && err_m < 255) err_m++;
      if (q.size() < DEPTH) q.push_back(e ? 8'h3F : d);
      else if (ovf_m < 255) ovf_m++;
    end
    prev_ready = r;
    check("tx_data", tx_data, last_tx);
    check("fifo_level", fifo_level, q.size());
    check("error_cnt", error_cnt, err_m);
    check("overflow_cnt", overflow_cnt, ovf_m);
    if (hold_busy) tx_busy = 1'b1;
    else if (rise_in > 0) begin
      rise_in--;
      if (rise_in == 0) begin
        tx_busy = 1'b1;
        busy_left = $urandom_range(1, 6);
      end
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) tx_busy = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] d, input logic e, input int hold);
    rx_data = d;
    rx_error = e;
    rx_ready = 1'b1;
    repeat (hold) step();
    rx_ready = 1'b0;
    rx_error = 1'b0;
    step();
  endtask

  task automatic wait_start(input string tag);
    int s, n;
    s = starts;
    n = 0;
    while (starts == s && n < 64) begin
      step();
      n++;
    end
    check({tag, "_start_seen"}, starts - s, 1);
  endtask

  task automatic drain(input string tag);
    int n, quiet;
    n = 0;
    quiet = 0;
    while (quiet < 14 && n < 3000) begin
      step();
      n++;
      quiet = (q.size() == 0 && !tx_busy && !hold_busy && rise_in == 0 && busy_left == 0) ? quiet + 1 : 0;
    end
    check({tag, "_drained"}, q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #1;
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_level", fifo_level, 0);
    check("rst_err", error_cnt, 0);
    check("rst_ovf", overflow_cnt, 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (10) step();
    rx_ready = 1'b0;
    step();
    check("no_capture_at_release", fifo_level, 0);
    check("no_echo_at_release", starts, 0);
    rx_data = 8'h55;
    rx_ready = 1'b1;
    step();
    c0 = cyc;
    rx_ready = 1'b0;
    wait_start("latency");
    check("latency", last_start - c0, 2);
    s0 = starts;
    send(8'hA5, 1'b0, 3);
    send(8'hFF, 1'b0, 1);
    drain("loopback");
    check("loopback_count", starts - s0, 2);
    check("loopback_last", tx_data, 8'hFF);
    send(8'h12, 1'b1, 1);
    drain("subst");
    check("subst_byte", tx_data, 8'h3F);
    check("subst_err_cnt", error_cnt, 1);
    s0 = starts;
    send(8'h77, 1'b0, 10);
    drain("held");
    check("held_one_capture", starts - s0, 1);
    rx_data = 8'h34;
    rx_error = 1'b1;
    rx_ready0 = 1'b1;
    step();
    rx_ready0 = 1'b0;
    rx_error = 1'b0;
    repeat (20) step();
    check("drop_err_cnt", error_cnt0, 1);
    check("drop_no_echo", starts0, 0);
    check("drop_level", fifo_level0, 0);
    hold_busy = 1'b1;
    tx_busy = 1'b1;
    for (int i = 0; i < 20; i++) send(8'(i), 1'b0, 1);
    check("ovf_level", fifo_level, 16);
    check("ovf_cnt", overflow_cnt, 4);
    s0 = starts;
    hold_busy = 1'b0;
    tx_busy = 1'b0;
    step();
    rx_data = 8'hEE;
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    check("launch_capture_start", tx_start, 1);
    check("launch_capture_level", fifo_level, 16);
    check("launch_capture_ovf", overflow_cnt, 4);
    drain("ovf");
    check("ovf_echo_count", starts - s0, 17);
    for (int i = 0; i < 400; i++) begin
      if (!rx_ready) begin
        rx_data = 8'($urandom);
        rx_error = $urandom_range(0, 7) == 0;
        rx_ready = $urandom_range(0, 3) == 0;
      end else rx_ready = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 31) == 0) echo_en = ~echo_en;
      step();
    end
    echo_en = 1'b1;
    rx_ready = 1'b0;
    rx_error = 1'b0;
    step();
    drain("random");
    never_busy = 1'b1;
    send(8'hA1, 1'b0, 1);
    send(8'hA2, 1'b0, 1);
    drain("timeout");
    check("timeout_gap_ok", (last_start - prev_start >= BT + 1) && (last_start - prev_start <= BT + 3), 1);
    check("timeout_last", tx_data, 8'hA2);
    never_busy = 1'b0;
    hold_busy = 1'b1;
    tx_busy = 1'b1;
    repeat (300) send(8'h00, 1'b1, 1);
    check("err_sat", error_cnt, 255);
    check("ovf_sat", overflow_cnt, 255);
    hold_busy = 1'b0;
    tx_busy = 1'b0;
    drain("sat");
    send(8'h5A, 1'b0, 1);
    wait_start("wd");
    hold_busy = 1'b1;
    tx_busy = 1'b1;
    rise_in = 0;
    busy_left = 0;
    send(8'h11, 1'b0, 1);
    send(8'h22, 1'b0, 1);
    step();
    #2;
    reset = 1'b1;
    #1;
    check("async_tx_start", tx_start, 0);
    check("async_level", fifo_level, 0);
    check("async_err", error_cnt, 0);
    q.delete();
    err_m = 0;
    ovf_m = 0;
    last_tx = 8'h00;
    prev_ready = 1'b1;
    hold_busy = 1'b0;
    tx_busy = 1'b0;
    s0 = starts;
    @(posedge clk);
    #3;
    reset = 1'b0;
    repeat (30) step();
    check("no_start_after_reset", starts - s0, 0);
    send(8'hC3, 1'b0, 1);
    drain("post_reset");
    check("post_reset_echo", starts - s0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
